rv_div_seq: RTL and testbench

//  Parametrised multi-cycle integer divider for the RV32IM M-extension datapath; successor to the single-op DIV unit.

---
 rtl/rv_div_pkg.sv | 26 ++
 rtl/rv_div_step.sv | 23 ++
 rtl/rv_div_seq.sv | 165 ++++++++++++++++
 tb/tb_rv_div_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_div_pkg.sv
// Shared types and opcode helpers for the sequential RV32M divider.
package rv_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed(div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_rem(div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift the outcome into q.
module rv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  assign shifted = {rem_in, q_in[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, b});

  // When the divisor fits, the difference is below b, so WIDTH bits suffice.
  assign rem_out = fits ? (shifted[WIDTH-1:0] - b) : shifted[WIDTH-1:0];
  assign q_out   = {q_in[WIDTH-2:0], fits};

endmodule

// File: rtl/rv_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with valid/ready handshakes and flush.
// Define RV_DIV_FAST_SPECIAL_EN to resolve b==0 and MIN/-1 directly from IDLE.
module rv_div_seq
  import rv_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_div,
  output logic             in_ready,
  input  logic [WIDTH-1:0] oper_a,
  input  logic [WIDTH-1:0] oper_b,
  input  logic [1:0]       operation,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] div_o,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [WIDTH-1:0] ALL_ONES  = '1;
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;

  div_op_e          op_in;
  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  div_op_e          op_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] fix_res;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // A flush in IDLE leaves in_ready up but still suppresses the accept.
  assign op_in  = div_op_e'(operation);
  assign accept = in_ready & enable_div & ~kill;

  assign a_neg  = is_signed(op_in) & oper_a[WIDTH-1];
  assign b_neg  = is_signed(op_in) & oper_b[WIDTH-1];
  assign b_zero = (oper_b == '0);
  assign a_mag  = a_neg ? -oper_a : oper_a;
  assign b_mag  = b_neg ? -oper_b : oper_b;

`ifdef RV_DIV_FAST_SPECIAL_EN
  logic             ovf;
  logic             special_hit;
  logic [WIDTH-1:0] special_res;

  assign ovf         = is_signed(op_in) & (oper_a == MIN_VAL) & (oper_b == ALL_ONES);
  assign special_hit = b_zero | ovf;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    special_res = '0;
    if (b_zero) special_res = is_rem(op_in) ? oper_a : ALL_ONES;
    else        special_res = is_rem(op_in) ? '0 : MIN_VAL;
  end
`endif

  rv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .q_in    (quo_q),
    .b       (b_q),
    .rem_out (rem_nxt),
    .q_out   (quo_nxt)
  );

  // A zero divisor must yield all-ones whatever the signs, so it never negates.
  // MIN/-1 falls out naturally: |MIN| / 1 = MIN, negated back to MIN.
  assign q_fix   = q_neg_q ? -quo_q : quo_q;
  assign r_fix   = r_neg_q ? -rem_q : rem_q;
  assign fix_res = is_rem(op_q) ? r_fix : q_fix;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      div_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
`ifdef RV_DIV_FAST_SPECIAL_EN
            if (special_hit) begin
              div_o <= special_res;
              state <= ST_DONE;
            end else begin
              count <= '0;
              state <= ST_CALC;
            end
`else
            count <= '0;
            state <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            count <= count + 1'b1;
            if (count == LAST_STEP) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            div_o <= fix_res;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (kill || out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: datapath registers have no reset; they are always loaded on accept
  // before anything reads them, and only control state must be defined.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= op_in;
      q_neg_q <= (a_neg ^ b_neg) & ~b_zero;
      r_neg_q <= a_neg;
      rem_q   <= '0;
      quo_q   <= a_mag;
      b_q     <= b_mag;
    end else if (state == ST_CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_rv_div_seq.sv
// Directed self-checking bench for rv_div_seq at WIDTH=32.
// Honours RV_DIV_FAST_SPECIAL_EN for the expected special-case latency.
module tb_rv_div_seq;

  localparam int W       = 32;
  localparam int LAT     = W + 2;
  localparam int MAX_WAIT = 200;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable_div;
  logic         in_ready;
  logic [W-1:0] oper_a;
  logic [W-1:0] oper_b;
  logic [1:0]   operation;
  logic         kill;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] div_o;
  logic         busy;

  int vectors    = 0;
  int miscompares = 0;

  rv_div_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable_div (enable_div),
    .in_ready   (in_ready),
    .oper_a     (oper_a),
    .oper_b     (oper_b),
    .operation  (operation),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_o      (div_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Latency = posedges from the accept edge (inclusive) until out_valid is seen.
  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef RV_DIV_FAST_SPECIAL_EN
    if (b == '0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return LAT;
  endfunction

  function automatic logic [W-1:0] ref_div(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   if (b == '0) return '1; else if (ovf) return a; else return W'($signed(a) / $signed(b));
      2'b01:   if (b == '0) return '1; else return a / b;
      2'b10:   if (b == '0) return a;  else if (ovf) return '0; else return W'($signed(a) % $signed(b));
      default: if (b == '0) return a;  else return a % b;
    endcase
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return '0;
      3:       return 32'h1;
      4:       return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  // Transaction driver: must be entered just after a negedge; returns after the
  // output handshake edge when out_ready is high.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    operation  = op;
    oper_a     = a;
    oper_b     = b;
    enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    lat = 1;
    while (!out_valid && lat < MAX_WAIT) begin
      @(negedge clk);
      lat++;
    end
    res = div_o;
    if (out_valid && out_ready) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || div_o !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b busy=%b div_o=%h, want 1 0 0 0",
               in_ready, out_valid, busy, div_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    vec_t         tbl [4];
    logic [W-1:0] res;
    int           lat;
    tbl = '{'{2'b00, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFD},
            '{2'b10, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFF},
            '{2'b01, 32'd100,       32'd7,   32'd14},
            '{2'b11, 32'd100,       32'd7,   32'd2}};
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      vectors++;
      if (res !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL basic[%0d] op=%b a=%h b=%h: got %h want %h",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, tbl[i].exp);
      end
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, LAT);
      end
    end
  endtask

  task automatic test_corners();
    vec_t         tbl [20];
    logic [W-1:0] res;
    int           lat;
    int           want_lat;
    tbl = '{'{2'b01, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF},
            '{2'b10, 32'h0000_1234, 32'h0,         32'h0000_1234},
            '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
            '{2'b00, 32'h8000_0000, 32'h0,         32'hFFFF_FFFF},
            '{2'b10, 32'h8000_0000, 32'h0,         32'h8000_0000},
            '{2'b00, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF},
            '{2'b11, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF},
            '{2'b00, 32'h8000_0000, 32'h1,         32'h8000_0000},
            '{2'b10, 32'h8000_0000, 32'h1,         32'h0},
            '{2'b00, 32'h1,         32'h1,         32'h1},
            '{2'b00, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF},
            '{2'b00, 32'h0,         32'hFFFF_FFFF, 32'h0},
            '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1},
            '{2'b11, 32'hFFFF_FFFF, 32'h10,        32'hF},
            '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0},
            '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{2'b00, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
            '{2'b10, 32'h7,         32'hFFFF_FFFE, 32'h1},
            '{2'b10, 32'hFFFF_FFFB, 32'h7,         32'hFFFF_FFFB}};
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      want_lat = exp_lat(tbl[i].op, tbl[i].a, tbl[i].b);
      vectors++;
      if (res !== tbl[i].exp) begin
        miscompares++;
        $display("FAIL corner[%0d] op=%b a=%h b=%h: got %h want %h",
                 i, tbl[i].op, tbl[i].a, tbl[i].b, res, tbl[i].exp);
      end
      vectors++;
      if (lat !== want_lat) begin
        miscompares++;
        $display("FAIL corner_latency[%0d]: got %0d want %0d", i, lat, want_lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    out_ready  = 1'b0;
    operation  = 2'b00;
    oper_a     = 32'hFFFF_FFF9;
    oper_b     = 32'd2;
    enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    guard = 0;
    while (!out_valid && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || div_o !== 32'hFFFF_FFFD || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got out_valid=%b div_o=%h in_ready=%b, want 1 fffffffd 0",
                 i, out_valid, div_o, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL release: got out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_kill();
    int   guard;
    logic seen;
    operation  = 2'b00;
    oper_a     = 32'd1000;
    oper_b     = 32'd3;
    enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    repeat (10) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_pre_busy: got %b want 1", busy);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_calc: got busy=%b in_ready=%b out_valid=%b, want 0 1 0",
               busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_no_result: got out_valid seen=%b want 0", seen);
    end

    // Flush while idle must swallow the request.
    kill       = 1'b1;
    enable_div = 1'b1;
    @(negedge clk);
    kill       = 1'b0;
    enable_div = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_idle_blocks: got busy=%b want 0", busy);
    end

    // Flush while a result waits in DONE.
    out_ready  = 1'b0;
    operation  = 2'b01;
    oper_a     = 32'd100;
    oper_b     = 32'd7;
    enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    guard = 0;
    while (!out_valid && guard < MAX_WAIT) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (out_valid !== 1'b1 || div_o !== 32'd14) begin
      miscompares++;
      $display("FAIL kill_done_pre: got out_valid=%b div_o=%h, want 1 0000000e", out_valid, div_o);
    end
    kill = 1'b1;
    @(negedge clk);
    kill      = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_done: got out_valid=%b busy=%b, want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int           lat;
    operation  = 2'b10;
    oper_a     = 32'd12345;
    oper_b     = 32'd11;
    enable_div = 1'b1;
    @(negedge clk);
    enable_div = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || div_o !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got in_ready=%b out_valid=%b busy=%b div_o=%h, want 1 0 0 0",
               in_ready, out_valid, busy, div_o);
    end
    rst = 1'b0;
    @(negedge clk);
    do_op(2'b11, 32'd100, 32'd7, res, lat);
    vectors++;
    if (res !== 32'd2 || lat !== LAT) begin
      miscompares++;
      $display("FAIL after_reset_op: got %h lat %0d, want 00000002 lat %0d", res, lat, LAT);
    end
  endtask

  task automatic test_random();
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] want;
    int           lat;
    int           want_lat;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      do_op(op, a, b, res, lat);
      want     = ref_div(op, a, b);
      want_lat = exp_lat(op, a, b);
      vectors++;
      if (res !== want || lat !== want_lat) begin
        miscompares++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: got %h lat %0d, want %h lat %0d",
                 i, op, a, b, res, lat, want, want_lat);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    enable_div = 1'b0;
    oper_a     = '0;
    oper_b     = '0;
    operation  = 2'b00;
    kill       = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_kill();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
